// File: rtl/control_estados_pkg.sv
// ---------------------------------------------------------------------------
// control_estados_pkg
// Shared definitions for the state-control block and the 7-segment display
// stage: the 2-bit state encoding and the default timing parameters.
// ---------------------------------------------------------------------------
package control_estados_pkg;

  // Same encoding is consumed by the display stage on its estado_in input.
  typedef enum logic [1:0] {
    E0 = 2'b00,
    E1 = 2'b01,
    E2 = 2'b10,
    E3 = 2'b11
  } estado_t;

  // 10 ms debounce and 10 s inactivity timeout at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int TIMEOUT_CYCLES_DEF  = 500000000;

endpackage

// File: rtl/control_estados_debounce_boton.sv
// ---------------------------------------------------------------------------
// debounce_boton
// Conditions one raw push-button: 2-flop synchroniser, debounce counter and
// a one-cycle pulse on each accepted 0->1 transition (releases are silent).
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   boton_in  in   raw asynchronous button level, active-high
//   pulso_o   out  one-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module debounce_boton
  import control_estados_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_in,
  output logic pulso_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic          nivel_q;
  logic          pulso_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // Stage p0 -> p1: metastability guard on the raw input.
      sync_p0 <= boton_in;
      sync_p1 <= sync_p0;
      // Debounce stage: nivel_q only follows sync_p1 after it has differed
      // for DEBOUNCE_CYCLES consecutive cycles.
      pulso_q <= 1'b0;
      if (sync_p1 == nivel_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        nivel_q <= sync_p1;
        cnt_q   <= '0;
        // Pulse is registered together with the level change so the FSM
        // sees it one edge later, giving DEBOUNCE_CYCLES+3 total latency.
        pulso_q <= sync_p1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/control_estados.sv
// ---------------------------------------------------------------------------
// control_estados
// Upstream stage of the 7-segment state display. Turns two raw buttons
// (advance / retreat) into a 2-bit wrap-around state code.
//
// Optional feature (macro CONTROL_ESTADOS_AUTO_RETURN_EN): inactivity
// timeout that returns the FSM to E0 after TIMEOUT_CYCLES idle cycles.
// Without the macro no timeout counter exists and timeout_o is always 0.
//
// Ports:
//   clk                  in   system clock, rising edge
//   reset                in   synchronous, active-high
//   boton_avanzar_in     in   raw button: advance one state
//   boton_retroceder_in  in   raw button: go back one state
//   estado_o[1:0]        out  registered state code (display estado_in)
//   cambio_o             out  one-cycle pulse when estado_o takes a new value
//   timeout_o            out  one-cycle pulse on an auto-return to E0
// ---------------------------------------------------------------------------
module control_estados
  import control_estados_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_avanzar_in,
  input  logic       boton_retroceder_in,
  output logic [1:0] estado_o,
  output logic       cambio_o,
  output logic       timeout_o
);

  logic    pulso_av;
  logic    pulso_re;
  estado_t estado_q;
  estado_t estado_d;
  logic    cambio_q;
  logic    cambio_d;
  logic    timeout_q;
  logic    timeout_d;

  debounce_boton #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_avanzar (
    .clk     (clk),
    .reset   (reset),
    .boton_in(boton_avanzar_in),
    .pulso_o (pulso_av)
  );

  debounce_boton #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_retroceder (
    .clk     (clk),
    .reset   (reset),
    .boton_in(boton_retroceder_in),
    .pulso_o (pulso_re)
  );

`ifdef CONTROL_ESTADOS_AUTO_RETURN_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q;
  logic [TW-1:0] to_cnt_d;
`else
  // Keeps the otherwise unused parameter referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= E0;
      cambio_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CONTROL_ESTADOS_AUTO_RETURN_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      cambio_q  <= cambio_d;
      timeout_q <= timeout_d;
`ifdef CONTROL_ESTADOS_AUTO_RETURN_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cambio_d  = 1'b0;
    timeout_d = 1'b0;
    // Simultaneous presses cancel out; state arithmetic wraps modulo 4.
    case ({pulso_av, pulso_re})
      2'b10: begin
        estado_d = estado_t'(estado_q + 2'd1);
        cambio_d = 1'b1;
      end
      2'b01: begin
        estado_d = estado_t'(estado_q - 2'd1);
        cambio_d = 1'b1;
      end
      default: ;
    endcase
`ifdef CONTROL_ESTADOS_AUTO_RETURN_EN
    to_cnt_d = to_cnt_q;
    // Any press takes priority over a coinciding timeout and restarts it.
    if (pulso_av || pulso_re || (estado_q == E0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      estado_d  = E0;
      cambio_d  = 1'b1;
      timeout_d = 1'b1;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
`endif
  end

  assign estado_o  = estado_q;
  assign cambio_o  = cambio_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_control_estados.sv
// Directed bench for control_estados with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_control_estados;

  logic       clk = 1'b0;
  logic       reset;
  logic       boton_a;
  logic       boton_r;
  logic [1:0] estado_o;
  logic       cambio_o;
  logic       timeout_o;

  int n_chk = 0;
  int n_err = 0;
  int n_cb  = 0;
  int n_to  = 0;

  control_estados #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) u_dut (
    .clk                (clk),
    .reset              (reset),
    .boton_avanzar_in   (boton_a),
    .boton_retroceder_in(boton_r),
    .estado_o           (estado_o),
    .cambio_o           (cambio_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cambio_o === 1'b1) n_cb++;
    if (timeout_o === 1'b1) n_to++;
  endtask

  // Hold the given buttons for 10 edges, release for 7; check the final
  // state, the number of cambio pulses and (if a change is expected) that it
  // landed exactly 7 edges after the rise.
  task automatic press(input logic a, input logic r, input logic [1:0] exp_st,
                       input logic exp_chg, input string tag);
    int cb0;
    int prev;
    int at;
    cb0 = n_cb;
    at  = -1;
    boton_a = a;
    boton_r = r;
    for (int i = 1; i <= 10; i++) begin
      prev = n_cb;
      tick();
      if (n_cb != prev && at < 0) at = i;
    end
    boton_a = 1'b0;
    boton_r = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk({tag, "_estado"}, 32'(estado_o), 32'(exp_st));
    chk({tag, "_cambios"}, 32'(n_cb - cb0), exp_chg ? 32'd1 : 32'd0);
    if (exp_chg) chk({tag, "_latencia"}, 32'(at), 32'd7);
  endtask

  initial begin
    int cb0;
    int to0;
    int to_at;
    int to_cb;
    logic [1:0] to_st;
    reset   = 1'b1;
    boton_a = 1'b0;
    boton_r = 1'b0;
    tick();
    tick();
    chk("reset_estado", 32'(estado_o), 32'd0);
    chk("reset_cambio", 32'(cambio_o), 32'd0);
    chk("reset_timeout", 32'(timeout_o), 32'd0);
    reset = 1'b0;
    n_cb = 0;
    n_to = 0;

    // Idle: nothing moves.
    for (int i = 0; i < 50; i++) tick();
    chk("idle_estado", 32'(estado_o), 32'd0);
    chk("idle_cambios", 32'(n_cb), 32'd0);
    chk("idle_timeouts", 32'(n_to), 32'd0);

    // Four advances with wrap-around.
    press(1'b1, 1'b0, 2'b01, 1'b1, "av1");
    press(1'b1, 1'b0, 2'b10, 1'b1, "av2");
    press(1'b1, 1'b0, 2'b11, 1'b1, "av3");
    press(1'b1, 1'b0, 2'b00, 1'b1, "av4_wrap");
    chk("av_no_timeout", 32'(n_to), 32'd0);

    // Two-cycle glitch on advance is rejected (done in E0, no timeout runs).
    cb0 = n_cb;
    boton_a = 1'b1;
    tick();
    tick();
    boton_a = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("glitch_estado", 32'(estado_o), 32'd0);
    chk("glitch_cambios", 32'(n_cb - cb0), 32'd0);

    // Both buttons together: state held, no cambio.
    press(1'b1, 1'b1, 2'b00, 1'b0, "ambos");

    // Retreat wraps E0 -> E3, then advance back to E0.
    press(1'b0, 1'b1, 2'b11, 1'b1, "re_wrap");
    press(1'b1, 1'b0, 2'b00, 1'b1, "av_back");

    // Inactivity: advance to E1 and idle.
    boton_a = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    chk("to_pre_estado", 32'(estado_o), 32'd1);
    to0   = n_to;
    to_at = -1;
    to_cb = 0;
    to_st = 2'b11;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (j == 3) boton_a = 1'b0;
      if (timeout_o === 1'b1 && to_at < 0) begin
        to_at = j;
        to_cb = 32'(cambio_o);
        to_st = estado_o;
      end
    end
`ifdef CONTROL_ESTADOS_AUTO_RETURN_EN
    chk("to_instante", 32'(to_at), 32'd20);
    chk("to_cambio", 32'(to_cb), 32'd1);
    chk("to_estado_evento", 32'(to_st), 32'd0);
    chk("to_pulsos", 32'(n_to - to0), 32'd1);
    chk("to_estado_final", 32'(estado_o), 32'd0);
`else
    chk("to_pulsos", 32'(n_to - to0), 32'd0);
    chk("to_estado_final", 32'(estado_o), 32'd1);
`endif

    // Reset mid-operation with debounce counter part-way.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    press(1'b1, 1'b0, 2'b01, 1'b1, "rs_av1");
    press(1'b1, 1'b0, 2'b10, 1'b1, "rs_av2");
    boton_a = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    chk("rs_mid_estado", 32'(estado_o), 32'd0);
    chk("rs_mid_cambio", 32'(cambio_o), 32'd0);
    chk("rs_mid_cnt", 32'(u_dut.u_avanzar.cnt_q), 32'd0);
    reset = 1'b0;
    cb0 = n_cb;
    // Button still held: full debounce needed after release of reset.
    for (int i = 1; i <= 6; i++) tick();
    chk("rs_hold_pre_estado", 32'(estado_o), 32'd0);
    chk("rs_hold_pre_cambios", 32'(n_cb - cb0), 32'd0);
    tick();
    chk("rs_hold_estado", 32'(estado_o), 32'd1);
    chk("rs_hold_cambio", 32'(cambio_o), 32'd1);
    boton_a = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("rs_hold_cambios", 32'(n_cb - cb0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
